// File: rtl/clk_divider_n.sv
// clk_divider_n: programmable integer clock divider, divide-by-N (N = 2..2**W-1)
// with 50% duty cycle for even and odd N. A new divisor (load/div_i) and the run
// enable take effect only at a period boundary, so clk_out never shows a runt.
//
// Ports:
//   clk      in   reference clock
//   rst      in   asynchronous active-high reset
//   en       in   run enable (sampled on clk posedge)
//   div_i    in   [W-1:0] new divisor, captured when load=1 (0/1 clamp to 2)
//   load     in   capture strobe for div_i
//   clk_out  out  divided clock
//   tick     out  1-clk pulse during the first cycle of every period
//   div_cur  out  [W-1:0] divisor currently in effect
//   running  out  high while periods are being generated
module clk_divider_n #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_i,
  input  logic         load,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] div_cur,
  output logic         running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] pend;
  logic [W-1:0] load_val;
  logic [W:0]   half_cur;
  logic         pend_vld;
  logic         pos_q;
  logic         neg_q;
  logic         boundary;

  always_comb begin
    boundary = (state == ST_RUN) && (cnt == div_cur - 1'b1);
    cnt_inc  = cnt + 1'b1;
    // H = ceil(N/2): number of period cycles with pos_q high
    half_cur = ({1'b0, div_cur} + 1'b1) >> 1;
    load_val = (div_i < W'(2)) ? W'(2) : div_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pos_q    <= 1'b0;
      tick     <= 1'b0;
      div_cur  <= W'(DEFAULT_DIV);
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_ARM;
        end
        ST_ARM: begin
          // First period after a start; a divisor loaded while stopped applies here.
          state <= ST_RUN;
          cnt   <= '0;
          pos_q <= 1'b1;
          tick  <= 1'b1;
          if (pend_vld) begin
            div_cur  <= pend;
            pend_vld <= 1'b0;
          end
        end
        ST_RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (pend_vld) begin
              div_cur  <= pend;
              pend_vld <= 1'b0;
            end
            if (en) begin
              pos_q <= 1'b1;
              tick  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              pos_q <= 1'b0;
            end
          end else begin
            cnt   <= cnt_inc;
            pos_q <= ({1'b0, cnt_inc} < half_cur);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Placed after the boundary update so a load on the boundary cycle stays
      // pending for the next boundary instead of being consumed now.
      if (load) begin
        pend     <= load_val;
        pend_vld <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  // Parity follows div_cur, which only changes when both phases are low.
  always_comb begin
    running = (state == ST_RUN);
    clk_out = div_cur[0] ? (pos_q & neg_q) : pos_q;
  end

endmodule

// File: tb/tb_clk_divider_n.sv
module tb_clk_divider_n;

  localparam int W           = 8;
  localparam int DEFAULT_DIV = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_i;
  logic         load;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         running;

  int n_cmp  = 0;
  int n_fail = 0;

  clk_divider_n #(.W(W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_i   (div_i),
    .load    (load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: period-level view. A period of length n starts either one
  // cycle after en is seen while stopped, or right after the previous period
  // ends with en still high. Each period start pushes its divisor on sb_q.
  int unsigned m_state;   // 0 stopped, 1 start pending, 2 running
  int unsigned m_k;       // cycle index within current period
  int unsigned m_n;       // divisor of current period
  int unsigned m_pend;
  bit          m_pv;
  bit          m_tick;
  bit          m_end;
  int unsigned sb_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_k     = 0;
      m_n     = DEFAULT_DIV;
      m_pv    = 0;
      m_tick  = 0;
      sb_q.delete();
    end else begin
      m_tick = 0;
      m_end  = (m_state == 1) || (m_state == 2 && m_k == m_n - 1);
      if (m_end) begin
        if (m_pv) begin
          m_n  = m_pend;
          m_pv = 0;
        end
        m_k = 0;
        if (m_state == 1 || en) begin
          m_state = 2;
          m_tick  = 1;
          sb_q.push_back(m_n);
        end else begin
          m_state = 0;
        end
      end else if (m_state == 2) begin
        m_k++;
      end else if (en) begin
        m_state = 1;
      end
      if (load) begin
        m_pend = (div_i < 2) ? 2 : div_i;
        m_pv   = 1;
      end
    end
  end

  // Expected clk_out in half-cycle units h from period start:
  // even N high for h in [0, N), odd N high for h in [1, N+1).
  function automatic int exp_clk(input int half);
    int h;
    if (m_state != 2) return 0;
    h = 2 * m_k + half;
    if (m_n % 2 == 0) return (h < m_n) ? 1 : 0;
    return (h >= 1 && h < m_n + 1) ? 1 : 0;
  endfunction

  // Monitor: per-edge waveform checks plus scoreboard pop on each DUT tick.
  always @(posedge clk) begin
    #1;
    chk("clk_out_pos", clk_out, exp_clk(0));
    chk("tick", tick, m_tick);
    chk("running", running, (m_state == 2) ? 1 : 0);
    if (tick) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_tick", 1, 0);
      end else begin
        chk("sb_div_cur", div_cur, sb_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("clk_out_neg", clk_out, exp_clk(1));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input int v);
    div_i = W'(v);
    load  = 1'b1;
    cyc();
    load  = 1'b0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (tick) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    load  = 1'b0;
    div_i = '0;
    #12;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    chk("rst_div_cur", div_cur, DEFAULT_DIV);
    cyc();
    rst = 1'b0;

    // default N=3
    repeat (14) cyc();
    chk("default_div", div_cur, DEFAULT_DIV);

    // load 4 mid-period
    wait_tick();
    do_load(4);
    repeat (14) cyc();

    // load 7 then 5 inside one period: 5 wins
    wait_tick();
    do_load(7);
    do_load(5);
    repeat (20) cyc();
    do_load(6);
    repeat (20) cyc();
    do_load(9);
    repeat (24) cyc();

    // clamp of 0 and 1 to 2
    do_load(0);
    repeat (14) cyc();
    chk("clamp0", div_cur, 2);
    do_load(1);
    repeat (10) cyc();
    chk("clamp1", div_cur, 2);

    // stop while clk_out high, then restart
    do_load(5);
    wait_tick();
    wait_tick();
    en = 1'b0;
    repeat (20) cyc();
    en = 1'b1;
    repeat (20) cyc();

    // async reset mid-period with odd N=5 and a pending load
    wait_tick();
    do_load(9);
    #1;
    chk("pre_rst_high", clk_out, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_clk_out", clk_out, 0);
    cyc();
    rst = 1'b0;
    repeat (20) cyc();
    chk("pend_discarded", div_cur, DEFAULT_DIV);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        if ($urandom_range(0, 19) == 0) div_i = W'($urandom_range(0, 40));
        else                            div_i = W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      cyc();
    end
    load = 1'b0;
    en   = 1'b1;
    repeat (3) cyc();
    #2;
    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
